// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: RISC-V execute stage. It has operand forwarding, a
// single-cycle ALU and an iterative M-extension unit (MDU). The MDU holds the
// front end through o_stall_e while it works.
// Optional feature macro: EXEC_MDU_DIV_EN builds the radix-2 restoring divider.
// Without the macro, DIV/DIVU/REM/REMU finish like one-cycle multiplies and
// return 0.

package exec_mdu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;
endpackage

module execute_stage_mdu
   import exec_mdu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MUL_CYCLES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
   input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
   input  logic [DATA_WIDTH-1:0] i_immext_e,
   input  logic [ADDR_WIDTH-1:0] i_pc_e,
   input  logic [ADDR_WIDTH-1:0] i_pc4_e,
   input  logic [4:0]            i_rd_addr_e,
   input  alu_op_t               i_aluctrl_e,
   input  logic                  i_alusrc_e,
   input  logic                  i_regwrite_e,
   input  logic                  i_memwrite_e,
   input  logic [1:0]            i_resultsrc_e,
   input  logic [1:0]            i_storetype_e,
   input  logic [1:0]            i_forward_a,
   input  logic [1:0]            i_forward_b,
   input  logic [DATA_WIDTH-1:0] i_forward_m,
   input  logic [DATA_WIDTH-1:0] i_forward_w,
   input  logic                  i_md_e,
   input  logic [2:0]            i_mdop_e,
   input  logic                  i_kill_e,
   output logic                  o_stall_e,
   output logic [ADDR_WIDTH-1:0] o_pctarget_e,
   output logic                  o_zero_e,
   output logic [DATA_WIDTH-1:0] o_alu_result_m,
   output logic [DATA_WIDTH-1:0] o_write_data_m,
   output logic                  o_regwrite_m,
   output logic                  o_memwrite_m,
   output logic [1:0]            o_resultsrc_m,
   output logic [1:0]            o_storetype_m,
   output logic [4:0]            o_rd_addr_m,
   output logic [ADDR_WIDTH-1:0] o_pc4_m
);
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;

   logic [DATA_WIDTH-1:0]   srca_s, srcb_fwd_s, srcb_s, alu_result_s, mdu_result_s;
   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   opa_q, opb_q;
   logic [2:0]              op_q;
   logic                    accept_s;
   logic [2*DATA_WIDTH-1:0] mula_s, mulb_s, prod_s;

`ifdef EXEC_MDU_DIV_EN
   logic [DATA_WIDTH-1:0] quo_q, rem_q, dvs_q, mag_a_s, mag_b_s, quo_res_s, rem_res_s;
   logic [DATA_WIDTH:0]   rsh_s, dif_s;
   logic                  negq_q, negr_q, sgn_s, div_zero_s, div_ovf_s;

   // Divider helpers: operand magnitudes, special cases, one restoring step, final signs
   always_comb begin
      sgn_s      = ~i_mdop_e[0];
      mag_a_s    = (sgn_s & srca_s[DATA_WIDTH-1]) ? (~srca_s + 1'b1) : srca_s;
      mag_b_s    = (sgn_s & srcb_fwd_s[DATA_WIDTH-1]) ? (~srcb_fwd_s + 1'b1) : srcb_fwd_s;
      div_zero_s = (srcb_fwd_s == '0);
      div_ovf_s  = sgn_s & (srca_s == {1'b1, {(DATA_WIDTH-1){1'b0}}}) & (srcb_fwd_s == '1);
      rsh_s      = {rem_q, quo_q[DATA_WIDTH-1]};
      dif_s      = rsh_s - {1'b0, dvs_q};
      quo_res_s  = negq_q ? (~quo_q + 1'b1) : quo_q;
      rem_res_s  = negr_q ? (~rem_q + 1'b1) : rem_q;
   end
`endif

   // Forwarding muxes and operand-B source select
   always_comb begin
      case (i_forward_a)
         2'b01:   srca_s = i_forward_w;
         2'b10:   srca_s = i_forward_m;
         default: srca_s = i_rs1_data_e;
      endcase
      case (i_forward_b)
         2'b01:   srcb_fwd_s = i_forward_w;
         2'b10:   srcb_fwd_s = i_forward_m;
         default: srcb_fwd_s = i_rs2_data_e;
      endcase
      srcb_s = i_alusrc_e ? i_immext_e : srcb_fwd_s;
   end

   // Single-cycle ALU
   always_comb begin
      case (i_aluctrl_e)
         ALU_ADD:   alu_result_s = srca_s + srcb_s;
         ALU_SUB:   alu_result_s = srca_s - srcb_s;
         ALU_AND:   alu_result_s = srca_s & srcb_s;
         ALU_OR:    alu_result_s = srca_s | srcb_s;
         ALU_XOR:   alu_result_s = srca_s ^ srcb_s;
         ALU_SLL:   alu_result_s = srca_s << srcb_s[CW-1:0];
         ALU_SRL:   alu_result_s = srca_s >> srcb_s[CW-1:0];
         ALU_SRA:   alu_result_s = $signed(srca_s) >>> srcb_s[CW-1:0];
         ALU_SLT:   alu_result_s = {{(DATA_WIDTH-1){1'b0}}, $signed(srca_s) < $signed(srcb_s)};
         ALU_SLTU:  alu_result_s = {{(DATA_WIDTH-1){1'b0}}, srca_s < srcb_s};
         ALU_PASSB: alu_result_s = srcb_s;
         default:   alu_result_s = '0;
      endcase
   end

   assign o_pctarget_e = i_pc_e + i_immext_e[ADDR_WIDTH-1:0];
   assign o_zero_e     = (alu_result_s == '0);
   assign o_stall_e    = i_md_e & ~i_kill_e & (state_q != S_DONE);
   assign accept_s     = (state_q == S_IDLE) & i_md_e & ~i_kill_e;

   // Product from latched operands; the extension mode picks the MULH flavour
   always_comb begin
      mula_s = {{DATA_WIDTH{opa_q[DATA_WIDTH-1] & (op_q[1:0] != 2'b11)}}, opa_q};
      mulb_s = {{DATA_WIDTH{opb_q[DATA_WIDTH-1] & ~op_q[1]}}, opb_q};
      prod_s = mula_s * mulb_s;
   end

   // MDU result select presented to EX/MEM in DONE
   always_comb begin
      if (!op_q[2]) begin
         mdu_result_s = (op_q[1:0] == 2'b00) ? prod_s[DATA_WIDTH-1:0]
                                             : prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      end else begin
`ifdef EXEC_MDU_DIV_EN
         mdu_result_s = op_q[1] ? rem_res_s : quo_res_s;
`else
         mdu_result_s = '0;
`endif
      end
   end

   // MDU sequencing: IDLE -> MUL/DIV -> DONE -> IDLE; kill always returns to IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (i_kill_e) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_md_e) begin
                  if (!i_mdop_e[2]) begin
                     state_d = S_MUL;
                     cnt_d   = CW'(MUL_CYCLES - 1);
                  end
`ifdef EXEC_MDU_DIV_EN
                  else if (div_zero_s || div_ovf_s) begin
                     state_d = S_DONE;
                     cnt_d   = '0;
                  end else begin
                     state_d = S_DIV;
                     cnt_d   = CW'(DATA_WIDTH - 1);
                  end
`else
                  else begin
                     state_d = S_MUL;
                     cnt_d   = '0;
                  end
`endif
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
            S_MUL, S_DIV: begin
               if (cnt_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM state and iteration counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Latch operands once at acceptance; the divider steps one bit per DIV cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         opa_q <= '0;
         opb_q <= '0;
         op_q  <= 3'd0;
`ifdef EXEC_MDU_DIV_EN
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
`endif
      end else if (accept_s) begin
         opa_q <= srca_s;
         opb_q <= srcb_fwd_s;
         op_q  <= i_mdop_e;
`ifdef EXEC_MDU_DIV_EN
         dvs_q <= mag_b_s;
         if (div_zero_s) begin
            quo_q  <= '1;
            rem_q  <= srca_s;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
         end else if (div_ovf_s) begin
            quo_q  <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            rem_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
         end else begin
            quo_q  <= mag_a_s;
            rem_q  <= '0;
            negq_q <= sgn_s & (srca_s[DATA_WIDTH-1] ^ srcb_fwd_s[DATA_WIDTH-1]);
            negr_q <= sgn_s & srca_s[DATA_WIDTH-1];
         end
      end else if (state_q == S_DIV) begin
         if (dif_s[DATA_WIDTH]) begin
            rem_q <= rsh_s[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
         end else begin
            rem_q <= dif_s[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
         end
`endif
      end
   end

   // EX/MEM register: bubble on stall or kill, MDU result in DONE, else ALU result
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_alu_result_m <= '0;
         o_write_data_m <= '0;
         o_regwrite_m   <= 1'b0;
         o_memwrite_m   <= 1'b0;
         o_resultsrc_m  <= 2'd0;
         o_storetype_m  <= 2'd0;
         o_rd_addr_m    <= 5'd0;
         o_pc4_m        <= '0;
      end else if (i_kill_e || o_stall_e) begin
         o_regwrite_m <= 1'b0;
         o_memwrite_m <= 1'b0;
      end else begin
         o_alu_result_m <= i_md_e ? mdu_result_s : alu_result_s;
         o_write_data_m <= srcb_fwd_s;
         o_regwrite_m   <= i_regwrite_e;
         o_memwrite_m   <= i_memwrite_e;
         o_resultsrc_m  <= i_resultsrc_e;
         o_storetype_m  <= i_storetype_e;
         o_rd_addr_m    <= i_rd_addr_e;
         o_pc4_m        <= i_pc4_e;
      end
   end
endmodule
